// File: rtl/program_loader.sv
// program_loader: frames a UART byte stream into 3-byte program-memory writes
// and holds the softcore in reset until a load completes with a good checksum.
module program_loader #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int MAX_COMMANDS  = 64,
  parameter int TIMEOUT_MS    = 10
) (
  input  logic        clk_in,
  input  logic        nrst_in,
  input  logic [7:0]  rx_data_in,
  input  logic        rx_valid_in,
  output logic        prog_we_out,
  output logic [7:0]  prog_addr_out,
  output logic [23:0] prog_cmd_out,
  output logic        core_nrst_out,
  output logic        busy_out,
  output logic        done_out,
  output logic        error_out
);
  localparam int TIMEOUT_CYCLES = CLK_FREQUENCY / 1000 * TIMEOUT_MS;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [8:0] MAX_C = 9'(MAX_COMMANDS);
  typedef enum logic [2:0] {IDLE, COUNT, INSTR, ADDR, DATA, CHECK} state_t;
  state_t state_q, state_d;
  logic [7:0] count_q, count_d, idx_q, idx_d, sum_q, sum_d;
  logic [7:0] instr_q, instr_d, addr_q, addr_d, paddr_q, paddr_d;
  logic [23:0] cmd_q, cmd_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic we_q, we_d, core_nrst_q, core_nrst_d, done_q, done_d, error_q, error_d;
  logic timeout;
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d = idx_q;
    sum_d = sum_q;
    instr_d = instr_q;
    addr_d = addr_q;
    paddr_d = paddr_q;
    cmd_d = cmd_q;
    we_d = 1'b0;
    core_nrst_d = core_nrst_q;
    done_d = done_q;
    error_d = error_q;
    // a strobe in the expiry cycle wins over the timeout
    timeout = state_q != IDLE && !rx_valid_in && tmo_q == TW'(TIMEOUT_CYCLES - 1);
    tmo_d = (state_q == IDLE || rx_valid_in || timeout) ? '0 : tmo_q + 1'b1;
    if (timeout) begin
      state_d = IDLE;
      error_d = 1'b1;
    end else if (rx_valid_in) begin
      case (state_q)
        IDLE: if (rx_data_in == 8'hA5) begin
          state_d = COUNT;
          done_d = 1'b0;
          error_d = 1'b0;
          core_nrst_d = 1'b0;
        end
        COUNT: if (rx_data_in == 8'h00 || {1'b0, rx_data_in} > MAX_C) begin
          state_d = IDLE;
          error_d = 1'b1;
        end else begin
          state_d = INSTR;
          count_d = rx_data_in;
          sum_d = rx_data_in;
          idx_d = 8'h00;
        end
        INSTR: begin
          state_d = ADDR;
          instr_d = rx_data_in;
          sum_d = sum_q + rx_data_in;
        end
        ADDR: begin
          state_d = DATA;
          addr_d = rx_data_in;
          sum_d = sum_q + rx_data_in;
        end
        DATA: begin
          state_d = (idx_q + 8'd1 == count_q) ? CHECK : INSTR;
          sum_d = sum_q + rx_data_in;
          we_d = 1'b1;
          paddr_d = idx_q;
          cmd_d = {instr_q, addr_q, rx_data_in};
          idx_d = idx_q + 8'd1;
        end
        CHECK: begin
          state_d = IDLE;
          done_d = rx_data_in == sum_q;
          error_d = rx_data_in != sum_q;
          core_nrst_d = rx_data_in == sum_q;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      state_q <= IDLE;
      count_q <= '0;
      idx_q <= '0;
      sum_q <= '0;
      instr_q <= '0;
      addr_q <= '0;
      paddr_q <= '0;
      cmd_q <= '0;
      tmo_q <= '0;
      we_q <= 1'b0;
      core_nrst_q <= 1'b1;
      done_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q <= idx_d;
      sum_q <= sum_d;
      instr_q <= instr_d;
      addr_q <= addr_d;
      paddr_q <= paddr_d;
      cmd_q <= cmd_d;
      tmo_q <= tmo_d;
      we_q <= we_d;
      core_nrst_q <= core_nrst_d;
      done_q <= done_d;
      error_q <= error_d;
    end
  end
  assign prog_we_out = we_q;
  assign prog_addr_out = paddr_q;
  assign prog_cmd_out = cmd_q;
  assign core_nrst_out = core_nrst_q;
  assign busy_out = state_q != IDLE;
  assign done_out = done_q;
  assign error_out = error_q;
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed and random frames against a frame-level model
// of the loader (expected writes, checksum verdict and core reset per frame).
module tb_program_loader;
  localparam int MAXC = 4;
  logic clk = 1'b0, nrst = 1'b0, rx_valid = 1'b0;
  logic [7:0] rx_data = '0;
  logic prog_we, core_nrst, busy, done, error;
  logic [7:0] prog_addr;
  logic [23:0] prog_cmd;
  int total = 0, bad = 0;
  logic [7:0] fr[$];
  logic [31:0] exp_w[$], got_w[$];
  logic e_done, e_err, e_core;

  program_loader #(.CLK_FREQUENCY(10_000), .MAX_COMMANDS(MAXC), .TIMEOUT_MS(1)) dut (
    .clk_in(clk), .nrst_in(nrst), .rx_data_in(rx_data), .rx_valid_in(rx_valid),
    .prog_we_out(prog_we), .prog_addr_out(prog_addr), .prog_cmd_out(prog_cmd),
    .core_nrst_out(core_nrst), .busy_out(busy), .done_out(done), .error_out(error));

  always #5 clk = ~clk;

  always @(negedge clk) if (prog_we) got_w.push_back({prog_addr, prog_cmd});

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  // frame-level reference: what a whole frame must produce
  task automatic model();
    int n, s;
    exp_w.delete();
    n = fr[1];
    e_core = 1'b0;
    if (n == 0 || n > MAXC) begin
      e_done = 1'b0;
      e_err = 1'b1;
      return;
    end
    s = n;
    for (int i = 0; i < n; i++) begin
      exp_w.push_back({8'(i), fr[2+3*i], fr[3+3*i], fr[4+3*i]});
      s += fr[2+3*i] + fr[3+3*i] + fr[4+3*i];
    end
    e_done = fr[2+3*n] == 8'(s);
    e_err = !e_done;
    e_core = e_done;
  endtask

  task automatic build(input int n, input bit corrupt);
    int s;
    logic [7:0] b;
    fr.delete();
    fr.push_back(8'hA5);
    fr.push_back(8'(n));
    if (n == 0 || n > MAXC) return;
    s = n;
    for (int i = 0; i < 3 * n; i++) begin
      b = 8'($urandom);
      fr.push_back(b);
      s += b;
    end
    fr.push_back(corrupt ? 8'(s + $urandom_range(1, 255)) : 8'(s));
  endtask

  task automatic run_frame(input string tag, input int gap);
    model();
    got_w.delete();
    foreach (fr[i]) begin
      send(fr[i]);
      if (i + 1 < fr.size()) idle($urandom_range(0, gap));
    end
    idle(1);
    chk({tag, ".done"}, 32'(done), 32'(e_done));
    chk({tag, ".err"}, 32'(error), 32'(e_err));
    chk({tag, ".core"}, 32'(core_nrst), 32'(e_core));
    chk({tag, ".busy"}, 32'(busy), 0);
    idle(2);
    chk({tag, ".nwr"}, got_w.size(), exp_w.size());
    foreach (exp_w[i]) if (i < got_w.size()) chk({tag, ".wr"}, got_w[i], exp_w[i]);
    if (exp_w.size() > 0) chk({tag, ".hold"}, {prog_addr, prog_cmd}, exp_w[exp_w.size()-1]);
  endtask

  initial begin
    logic [7:0] nb;
    int n;
    #12;
    chk("rst.we", 32'(prog_we), 0);
    chk("rst.addrcmd", {prog_addr, prog_cmd}, 0);
    chk("rst.core", 32'(core_nrst), 1);
    chk("rst.flags", {busy, done, error}, 0);
    nrst = 1'b1;
    idle(2);
    fr = '{8'hA5, 8'h02, 8'h01, 8'h01, 8'h01, 8'h02, 8'h00, 8'h0A, 8'h11};
    run_frame("valid", 0);
    fr = '{8'hA5, 8'h02, 8'h01, 8'h01, 8'h01, 8'h02, 8'h00, 8'h0A, 8'h12};
    run_frame("badsum", 0);
    fr = '{8'hA5, 8'h02, 8'h01, 8'h01, 8'h01, 8'h02, 8'h00, 8'h0A, 8'h11};
    run_frame("reload", 0);
    fr = '{8'hA5, 8'h00};
    run_frame("n0", 0);
    fr = '{8'hA5, 8'(MAXC + 1)};
    run_frame("nmax1", 0);
    build(MAXC, 1'b0);
    run_frame("nmax", 0);
    got_w.delete();
    send(8'h00);
    send(8'h5A);
    idle(3);
    chk("noise.flags", {busy, done, error, core_nrst}, {1'b0, e_done, e_err, e_core});
    chk("noise.nwr", got_w.size(), 0);
    fr = '{8'hA5, 8'h01, 8'hA5, 8'hA5, 8'hA5, 8'h10};
    run_frame("inA5", 0);
    // timeout: 10 silent cycles after the 0x07 strobe
    got_w.delete();
    send(8'hA5);
    send(8'h01);
    send(8'h07);
    idle(10);
    chk("tmo.before", {busy, error}, 2'b10);
    idle(1);
    chk("tmo.err", {busy, error, done, core_nrst}, 4'b0100);
    chk("tmo.nwr", got_w.size(), 0);
    // a strobe landing in the expiry cycle is processed instead
    send(8'hA5);
    send(8'h01);
    send(8'h07);
    idle(9);
    send(8'h08);
    idle(1);
    chk("tmo.saved", {busy, error}, 2'b10);
    send(8'h09);
    send(8'h19);
    idle(1);
    chk("tmo.saved.done", {done, error, core_nrst}, 3'b101);
    idle(2);
    chk("tmo.saved.wr", got_w.size() > 0 ? got_w[got_w.size()-1] : 32'hFFFFFFFF, 32'h00070809);
    // reset in the middle of a frame
    send(8'hA5);
    send(8'h02);
    send(8'h01);
    send(8'h01);
    idle(1);
    #1 nrst = 1'b0;
    #1;
    chk("midrst.out", {prog_we, prog_addr, prog_cmd}, 0);
    chk("midrst.flags", {busy, done, error, core_nrst}, 4'b0001);
    idle(1);
    nrst = 1'b1;
    fr = '{8'hA5, 8'h02, 8'h01, 8'h01, 8'h01, 8'h02, 8'h00, 8'h0A, 8'h11};
    run_frame("afterrst", 0);
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        nb = 8'($urandom);
        send(nb == 8'hA5 ? 8'h3C : nb);
        idle(1);
      end
      n = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1) * (MAXC + 1 + $urandom_range(0, 200)) : $urandom_range(1, MAXC);
      build(n, $urandom_range(0, 3) == 0);
      run_frame($sformatf("rnd%0d", k), 3);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
